sipo8: RTL

Serial-to-parallel receiver for 8-bit frames, the expanding counterpart of the 8-input reduction gates: it collects one data bit per accepted cycle on a single line and presents the completed frame on eight parallel outputs. It has a bit counter, a two-state framing FSM, and a separate output holding register with a valid/ready handshake, so the next frame can shift in while the previous word waits for its consumer. It sits between a serial link front end and the parallel gate-level datapath.

---
 rtl/sipo8.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/sipo8.sv
// sipo8: serial-to-parallel receiver for 8-bit frames.
//
// Collects one bit per accepted cycle from IN0 and presents each completed
// frame on OUT0..OUT7. A separate holding register with a valid/ready
// handshake lets the next frame shift in while the previous word waits.
//
// Parameters:
//   MSB_FIRST  0: first received bit lands on OUT0; 1: first bit lands on OUT7.
//
// Ports:
//   CLK        clock, rising edge active
//   RST        asynchronous active-high reset
//   IN0        serial data bit
//   IN_VALID   IN0 is sampled this cycle
//   START      (with IN_VALID) IN0 is bit 0 of a new frame
//   OUT_READY  consumer accepts the held word
//   OUT0..OUT7 held parallel word
//   OUT_VALID  held word is valid
//   ZERO       held word is all zeros
//   BUSY       a frame is partially received
//   OVERRUN    one-cycle pulse: a completed frame was dropped
module sipo8 #(
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic CLK,
  input  logic RST,
  input  logic IN0,
  input  logic IN_VALID,
  input  logic START,
  input  logic OUT_READY,
  output logic OUT0,
  output logic OUT1,
  output logic OUT2,
  output logic OUT3,
  output logic OUT4,
  output logic OUT5,
  output logic OUT6,
  output logic OUT7,
  output logic OUT_VALID,
  output logic ZERO,
  output logic BUSY,
  output logic OVERRUN
);

  typedef enum logic [0:0] {StIdle, StShift} state_e;

  state_e      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [7:0]  shreg_q, shreg_d;
  logic [7:0]  word_q, word_d;
  logic        valid_q, valid_d;
  logic        zero_q, zero_d;
  logic        overrun_q, overrun_d;

  logic        accept;
  logic        complete;
  logic [2:0]  bit_idx;
  logic [2:0]  bit_pos;

  // START restarts a frame in any state; plain bits only count inside a frame.
  assign accept   = IN_VALID & (START | (state_q == StShift));
  assign complete = accept & ~START & (state_q == StShift) & (cnt_q == 3'd7);
  assign bit_idx  = START ? 3'd0 : cnt_q;
  assign bit_pos  = MSB_FIRST ? (3'd7 - bit_idx) : bit_idx;

  // Framing FSM, bit counter and shift register.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shreg_d = shreg_q;
    if (accept) begin
      // A restart discards the partial frame silently.
      if (START) begin
        shreg_d = 8'h00;
      end
      shreg_d[bit_pos] = IN0;
      if (complete) begin
        state_d = StIdle;
        cnt_d   = 3'd0;
      end else begin
        state_d = StShift;
        cnt_d   = bit_idx + 3'd1;
      end
    end
  end

  // Output holding register and handshake.
  always_comb begin
    word_d    = word_q;
    valid_d   = valid_q;
    zero_d    = zero_q;
    overrun_d = 1'b0;
    if (complete) begin
      if (!valid_q || OUT_READY) begin
        // shreg_d already includes the completing bit.
        word_d  = shreg_d;
        valid_d = 1'b1;
        zero_d  = ~|shreg_d;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (valid_q && OUT_READY) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= StIdle;
      cnt_q     <= 3'd0;
      shreg_q   <= 8'h00;
      word_q    <= 8'h00;
      valid_q   <= 1'b0;
      zero_q    <= 1'b1;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      shreg_q   <= shreg_d;
      word_q    <= word_d;
      valid_q   <= valid_d;
      zero_q    <= zero_d;
      overrun_q <= overrun_d;
    end
  end

  assign OUT0      = word_q[0];
  assign OUT1      = word_q[1];
  assign OUT2      = word_q[2];
  assign OUT3      = word_q[3];
  assign OUT4      = word_q[4];
  assign OUT5      = word_q[5];
  assign OUT6      = word_q[6];
  assign OUT7      = word_q[7];
  assign OUT_VALID = valid_q;
  assign ZERO      = zero_q;
  assign BUSY      = (state_q == StShift);
  assign OVERRUN   = overrun_q;

endmodule
